// File: rtl/refill_tracker_pkg.sv
// rtl/refill_tracker_pkg.sv - shared helpers for the refill tracker
package refill_tracker_pkg;

    // Widest valid-vector the popcount helper accepts; DEPTH must not exceed it.
    localparam int unsigned POPCOUNT_MAX = 64;

    function automatic int unsigned popcount(input logic [POPCOUNT_MAX-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POPCOUNT_MAX; i++) begin
            cnt += 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/refill_tracker_ffs.sv
// rtl/refill_tracker_ffs.sv - lowest-set-bit finder (onehot, binary index, found)
//
// Ports:
//   req     in   WIDTH   request vector
//   onehot  out  WIDTH   only the lowest set bit of req
//   bin     out  IW      index of the lowest set bit (0 when none)
//   found   out  1       req has at least one bit set
module refill_tracker_ffs #(
    parameter int WIDTH = 8,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic [IW-1:0]    bin,
    output logic             found
);

    always_comb begin
        onehot = '0;
        bin    = '0;
        found  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i] && !found) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                bin       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/refill_tracker_param.sv
// rtl/refill_tracker_param.sv - outstanding L1.5 refill tracker keyed by AXI ID
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   push_req_i/ID_i/addr_i        allocate an entry; push_gnt_o / push_error_o (duplicate ID)
//   push_full_o                   all entries valid
//   pop_i/pop_ID_i                release the entry holding pop_ID_i; pop_addr_o, pop_error_o
//   pop_empty_o                   no entry valid
//   RESP_check_req_i/ID_i         RESP_check_is_valid_o: ID is outstanding
//   ADDR_check_req_i/addr_i       ADDR_check_hit_o / ADDR_check_ID_o: lowest matching entry
//   occupancy_o                   number of valid entries
//   timeout_o / timeout_idx_o     some entry reached TIMEOUT cycles; lowest such index
module refill_tracker_param
    import refill_tracker_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ID_WIDTH   = 14,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_req_i,
    input  logic [ID_WIDTH-1:0]        push_ID_i,
    input  logic [ADDR_WIDTH-1:0]      push_addr_i,
    output logic                       push_gnt_o,
    output logic                       push_full_o,
    output logic                       push_error_o,
    input  logic                       pop_i,
    input  logic [ID_WIDTH-1:0]        pop_ID_i,
    output logic [ADDR_WIDTH-1:0]      pop_addr_o,
    output logic                       pop_empty_o,
    output logic                       pop_error_o,
    input  logic                       RESP_check_req_i,
    input  logic [ID_WIDTH-1:0]        RESP_check_ID_i,
    output logic                       RESP_check_is_valid_o,
    input  logic                       ADDR_check_req_i,
    input  logic [ADDR_WIDTH-1:0]      ADDR_check_addr_i,
    output logic                       ADDR_check_hit_o,
    output logic [ID_WIDTH-1:0]        ADDR_check_ID_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic                       timeout_o,
    output logic [$clog2(DEPTH)-1:0]   timeout_idx_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;
    // With TIMEOUT==0 the age field collapses to one bit that never moves.
    localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic                  valid;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [AGE_W-1:0]      age;
    } entry_t;

    entry_t           ent_q [DEPTH];
    logic [OCC_W-1:0] occ_q;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] push_match;
    logic [DEPTH-1:0] pop_match;
    logic [DEPTH-1:0] resp_match;
    logic [DEPTH-1:0] addr_match;
    logic [DEPTH-1:0] expired;
    logic [DEPTH-1:0] valid_next;

    logic [DEPTH-1:0] free_onehot;
    logic [IDX_W-1:0] free_bin;
    logic             free_found;
    logic [DEPTH-1:0] addr_onehot;
    logic [IDX_W-1:0] addr_bin;
    logic             addr_found;
    logic [DEPTH-1:0] exp_onehot;
    logic [IDX_W-1:0] exp_bin;
    logic             exp_found;

    logic dup;
    logic pop_hit;
    logic pop_fire;

    always_comb begin
        valid_vec  = '0;
        push_match = '0;
        pop_match  = '0;
        resp_match = '0;
        addr_match = '0;
        expired    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i]  = ent_q[i].valid;
            push_match[i] = ent_q[i].valid && (ent_q[i].id == push_ID_i);
            pop_match[i]  = ent_q[i].valid && (ent_q[i].id == pop_ID_i);
            resp_match[i] = ent_q[i].valid && (ent_q[i].id == RESP_check_ID_i);
            addr_match[i] = ent_q[i].valid && (ent_q[i].addr == ADDR_check_addr_i);
            expired[i]    = (TIMEOUT > 0) && ent_q[i].valid
                            && (ent_q[i].age == AGE_W'(TIMEOUT));
        end
    end

    assign free_vec = ~valid_vec;

    refill_tracker_ffs #(.WIDTH(DEPTH)) u_free_ffs (
        .req    (free_vec),
        .onehot (free_onehot),
        .bin    (free_bin),
        .found  (free_found)
    );

    refill_tracker_ffs #(.WIDTH(DEPTH)) u_addr_ffs (
        .req    (addr_match),
        .onehot (addr_onehot),
        .bin    (addr_bin),
        .found  (addr_found)
    );

    refill_tracker_ffs #(.WIDTH(DEPTH)) u_exp_ffs (
        .req    (expired),
        .onehot (exp_onehot),
        .bin    (exp_bin),
        .found  (exp_found)
    );

    // Finder outputs that this instance configuration does not consume.
    logic unused_ffs;
    assign unused_ffs = ^{free_bin, free_found, addr_bin, exp_onehot};

    assign dup          = |push_match;
    assign push_full_o  = (occ_q == OCC_W'(DEPTH));
    // Full is judged on registered state: a pop in the same cycle does not make room.
    assign push_gnt_o   = push_req_i & ~push_full_o & ~dup;
    assign push_error_o = push_req_i & dup;

    assign pop_hit      = |pop_match;
    assign pop_fire     = pop_i & pop_hit;
    assign pop_error_o  = pop_i & ~pop_hit;
    assign pop_empty_o  = (occ_q == '0);

    assign RESP_check_is_valid_o = RESP_check_req_i & (|resp_match);
    assign ADDR_check_hit_o      = ADDR_check_req_i & addr_found;

    assign occupancy_o   = occ_q;
    assign timeout_o     = exp_found;
    assign timeout_idx_o = exp_bin;

    // IDs and the address finder onehot select at most one entry, so OR-muxing is exact.
    always_comb begin
        pop_addr_o      = '0;
        ADDR_check_ID_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pop_i && pop_match[i]) begin
                pop_addr_o = pop_addr_o | ent_q[i].addr;
            end
            if (ADDR_check_req_i && addr_onehot[i]) begin
                ADDR_check_ID_o = ADDR_check_ID_o | ent_q[i].id;
            end
        end
    end

    assign valid_next = (valid_vec & ~({DEPTH{pop_fire}} & pop_match))
                      | ({DEPTH{push_gnt_o}} & free_onehot);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // A push only targets a free entry and a pop only a valid one, so they never collide.
                if (push_gnt_o && free_onehot[i]) begin
                    ent_q[i].valid <= 1'b1;
                    ent_q[i].id    <= push_ID_i;
                    ent_q[i].addr  <= push_addr_i;
                    ent_q[i].age   <= '0;
                end else begin
                    if (pop_fire && pop_match[i]) begin
                        ent_q[i].valid <= 1'b0;
                    end
                    if ((TIMEOUT > 0) && ent_q[i].valid
                        && (ent_q[i].age != AGE_W'(TIMEOUT))) begin
                        ent_q[i].age <= ent_q[i].age + AGE_W'(1);
                    end
                end
            end
            occ_q <= OCC_W'(popcount(POPCOUNT_MAX'(valid_next)));
        end
    end

endmodule
